dm_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache between the CPU/MMU stage and main memory. It consumes the physical-address word bus that the CPU/MMU stage drives: address, write data, access type, cachable and io. It serves hits locally, refills whole lines from memory on read misses, and passes uncachable or io accesses straight through. All traffic is full 32-bit words; byte and halfword merging is done upstream.

---
 rtl/dm_cache_pkg.sv | 25 ++
 rtl/dm_cache_if.sv | 24 ++
 rtl/dm_cache_array.sv | 37 +++
 rtl/dm_cache.sv | 181 ++++++++++++++++++
 tb/tb_dm_cache.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache shared definitions: memory access codes, FSM state codes, default geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dm_cache_pkg;

  // Word-bus access type shared by the CPU/MMU side and the memory side.
  typedef logic [1:0] mem_access_t;
  localparam mem_access_t MEM_NONE = 2'd0;
  localparam mem_access_t MEM_R    = 2'd1;
  localparam mem_access_t MEM_W    = 2'd2;
  localparam mem_access_t MEM_X    = 2'd3;

  // Default cache geometry: 64 lines of 4 words.
  localparam int DEF_INDEX_BITS      = 6;
  localparam int DEF_LINE_WORDS_LOG2 = 2;

  // Cache controller states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_BYPASS = 3'd5;

endpackage

// File: rtl/dm_cache_if.sv
// Physical-address word bus: requester drives addr/data_out/access_type/cachable/io,
// responder returns data_in with a one-cycle ready pulse.
// Backpressure: requester holds its request stable until ready; NONE before ready aborts.
interface dm_cache_if;
  import dm_cache_pkg::*;

  logic [31:0] addr;
  logic [31:0] data_out;
  mem_access_t access_type;
  logic        cachable;
  logic        io;
  logic [31:0] data_in;
  logic        ready;

  modport master (
    output addr, data_out, access_type, cachable, io,
    input  data_in, ready
  );

  modport slave (
    input  addr, data_out, access_type, cachable, io,
    output data_in, ready
  );
endinterface

// File: rtl/dm_cache_array.sv
// Tag and data storage for dm_cache; one shared line index for read and write.
// Latency: combinational read, write takes effect at the next clk edge (one word per cycle).
// Backpressure: none; write enables come from the controller.
module dm_cache_array #(
  parameter int INDEX_BITS      = 6,
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int TAG_BITS        = 22
) (
  input  logic                       clk,
  input  logic [INDEX_BITS-1:0]      index,
  input  logic [LINE_WORDS_LOG2-1:0] rd_word,
  output logic [TAG_BITS-1:0]        rd_tag,
  output logic [31:0]                rd_data,
  input  logic                       tag_we,
  input  logic [TAG_BITS-1:0]        tag_wdata,
  input  logic                       data_we,
  input  logic [LINE_WORDS_LOG2-1:0] wr_word,
  input  logic [31:0]                wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << (INDEX_BITS + LINE_WORDS_LOG2);

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [WORDS];

  assign rd_tag  = tag_mem[index];
  assign rd_data = data_mem[{index, rd_word}];

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[index] <= tag_wdata;
    end
    if (data_we) begin
      data_mem[{index, wr_word}] <= wr_data;
    end
  end
endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-through, no-write-allocate cache between CPU/MMU and memory.
// Latency: read hit 2 cycles; miss refills a whole line; writes/bypass complete on mem ready.
// Backpressure: cpu.ready is a single pulse; memory request held stable until mem.ready.
// Ports: clk, res (sync active-low), cpu (slave word bus), mem (master word bus).
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int INDEX_BITS      = DEF_INDEX_BITS,
  parameter int LINE_WORDS_LOG2 = DEF_LINE_WORDS_LOG2
) (
  input  logic       clk,
  input  logic       res,
  dm_cache_if.slave  cpu,
  dm_cache_if.master mem
);
  localparam int TAG_BITS  = 30 - INDEX_BITS - LINE_WORDS_LOG2;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int INDEX_LSB = 2 + LINE_WORDS_LOG2;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_BITS;

  logic [2:0]                 state, state_nxt;
  logic [31:0]                req_addr, req_data, captured;
  mem_access_t                req_type;
  logic                       req_cachable, req_io;
  logic [LINE_WORDS_LOG2-1:0] refill_cnt;
  logic [LINES-1:0]           valid;

  logic [TAG_BITS-1:0]        req_tag, arr_tag;
  logic [INDEX_BITS-1:0]      req_index;
  logic [LINE_WORDS_LOG2-1:0] req_word, wr_word;
  logic [31:0]                arr_data, wr_data;
  logic                       hit, last_word, req_bypass, new_bypass;
  logic                       cpu_active;
  logic                       data_we, tag_we;

  assign req_word   = req_addr[INDEX_LSB-1:2];
  assign req_index  = req_addr[TAG_LSB-1:INDEX_LSB];
  assign req_tag    = req_addr[31:TAG_LSB];
  assign req_bypass = req_io || !req_cachable;
  assign new_bypass = cpu.io || !cpu.cachable;
  assign cpu_active = (cpu.access_type != MEM_NONE);
  assign hit        = valid[req_index] && (arr_tag == req_tag);
  assign last_word  = &refill_cnt;

  // Refill writes words in arrival order; write hits patch a single word.
  // Writes are suppressed while reset is asserted so a dropped transfer leaves no trace.
  assign wr_word = (state == S_REFILL) ? refill_cnt : req_word;
  assign wr_data = (state == S_REFILL) ? mem.data_in : req_data;
  assign data_we = res && mem.ready &&
                   ((state == S_REFILL) || ((state == S_WRITE) && hit));
  assign tag_we  = res && mem.ready && (state == S_REFILL) && last_word;

  dm_cache_array #(
    .INDEX_BITS      (INDEX_BITS),
    .LINE_WORDS_LOG2 (LINE_WORDS_LOG2),
    .TAG_BITS        (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .index     (req_index),
    .rd_word   (req_word),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .tag_we    (tag_we),
    .tag_wdata (req_tag),
    .data_we   (data_we),
    .wr_word   (wr_word),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk) begin
    if (!res) begin
      state      <= S_IDLE;
      valid      <= '0;
      refill_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOOKUP) begin
        refill_cnt <= '0;
      end
      if ((state == S_REFILL) && mem.ready) begin
        refill_cnt <= refill_cnt + LINE_WORDS_LOG2'(1);
        if (last_word) begin
          valid[req_index] <= 1'b1;
        end
      end
    end
  end

  // Request capture and refill word capture need no reset: they are only
  // consumed in states reached after being written.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && cpu_active) begin
      req_addr     <= cpu.addr;
      req_data     <= cpu.data_out;
      req_type     <= cpu.access_type;
      req_cachable <= cpu.cachable;
      req_io       <= cpu.io;
    end
    if ((state == S_REFILL) && mem.ready && (refill_cnt == req_word)) begin
      captured <= mem.data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cpu_active) begin
          if (new_bypass)                   state_nxt = S_BYPASS;
          else if (cpu.access_type == MEM_W) state_nxt = S_WRITE;
          else                              state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!cpu_active || hit) state_nxt = S_IDLE;
        else                    state_nxt = S_REFILL;
      end
      // An abort does not stop the refill: the line is always installed.
      S_REFILL: if (mem.ready && last_word) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      S_WRITE:  if (mem.ready) state_nxt = S_IDLE;
      S_BYPASS: if (mem.ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu.ready       = 1'b0;
    cpu.data_in     = '0;
    mem.access_type = MEM_NONE;
    mem.addr        = '0;
    mem.data_out    = '0;
    mem.cachable    = 1'b0;
    mem.io          = 1'b0;
    case (state)
      S_LOOKUP: begin
        if (cpu_active && hit) begin
          cpu.ready   = 1'b1;
          cpu.data_in = arr_data;
        end
      end
      S_REFILL: begin
        mem.access_type = MEM_R;
        mem.addr        = {req_addr[31:INDEX_LSB], refill_cnt, 2'b00};
        mem.cachable    = req_cachable;
        mem.io          = req_io;
      end
      S_RESP: begin
        if (cpu_active) begin
          cpu.ready   = 1'b1;
          cpu.data_in = captured;
        end
      end
      S_WRITE: begin
        mem.access_type = MEM_W;
        mem.addr        = req_addr;
        mem.data_out    = req_data;
        mem.cachable    = req_cachable;
        mem.io          = req_io;
        cpu.ready       = mem.ready && cpu_active;
      end
      S_BYPASS: begin
        mem.access_type = req_type;
        mem.addr        = req_addr;
        mem.data_out    = req_data;
        mem.cachable    = req_cachable;
        mem.io          = req_io;
        cpu.ready       = mem.ready && cpu_active;
        if (mem.ready) begin
          cpu.data_in = mem.data_in;
        end
      end
      default: ;
    endcase
  end

  // Bypass is only meaningful while the latched class is live; keep it referenced
  // so the class decode stays visible next to the state it selects.
  logic unused_bypass;
  assign unused_bypass = req_bypass;
endmodule

// File: tb/tb_dm_cache.sv
module tb_dm_cache;
  import dm_cache_pkg::*;

  localparam int IB    = DEF_INDEX_BITS;
  localparam int LW    = DEF_LINE_WORDS_LOG2;
  localparam int ILSB  = 2 + LW;
  localparam int TLSB  = ILSB + IB;
  localparam int NLINE = 1 << IB;
  localparam int NWORD = 1 << LW;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  dm_cache_if cpu_bus ();
  dm_cache_if mem_bus ();

  dm_cache u_dut (
    .clk (clk),
    .res (res),
    .cpu (cpu_bus),
    .mem (mem_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  bit [31:0] mem_a [bit [31:0]];

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
  } mop_t;
  mop_t mem_log[$];
  int mcnt = 0;
  int mlat = 1;

  always @(posedge clk) begin
    #2;
    if (!res) begin
      mem_bus.ready   = 1'b0;
      mem_bus.data_in = '0;
      mcnt = 0;
    end else if (mem_bus.ready) begin
      mem_bus.ready = 1'b0;
      mcnt = 0;
    end else if (mem_bus.access_type == MEM_NONE) begin
      mcnt = 0;
    end else begin
      if (mcnt == 0) mlat = $urandom_range(1, 3);
      mcnt++;
      if (mcnt >= mlat) begin
        if (mem_bus.access_type == MEM_W) mem_a[mem_bus.addr] = mem_bus.data_out;
        mem_bus.data_in = mem_rd(mem_bus.addr);
        mem_log.push_back('{t: mem_bus.access_type, a: mem_bus.addr, d: mem_bus.data_out});
        mem_bus.ready = 1'b1;
      end
    end
  end

  // ---------------- ready monitor ----------------
  int ready_cnt = 0;
  int dbl_rdy   = 0;
  bit prev_rdy  = 1'b0;
  always @(negedge clk) begin
    if (cpu_bus.ready === 1'b1) begin
      ready_cnt++;
      if (prev_rdy) dbl_rdy++;
    end
    prev_rdy = (cpu_bus.ready === 1'b1);
  end

  // ---------------- cache reference model ----------------
  bit        cv    [NLINE];
  bit [31:0] ctag  [NLINE];
  bit [31:0] cdata [NLINE][NWORD];

  function automatic bit line_hit(input bit [31:0] a);
    int idx = int'(a[TLSB-1:ILSB]);
    return cv[idx] && (ctag[idx] == (a >> TLSB));
  endfunction

  function automatic void install(input bit [31:0] a);
    int idx = int'(a[TLSB-1:ILSB]);
    bit [31:0] base = (a >> ILSB) << ILSB;
    cv[idx]   = 1'b1;
    ctag[idx] = a >> TLSB;
    for (int i = 0; i < NWORD; i++) cdata[idx][i] = mem_rd(base + 32'(4 * i));
  endfunction

  task automatic check_refill(input string tag, input bit [31:0] a);
    bit [31:0] base = (a >> ILSB) << ILSB;
    check({tag, "/nops"}, mem_log.size(), NWORD);
    for (int i = 0; i < NWORD && i < mem_log.size(); i++) begin
      check({tag, "/raddr"}, mem_log[i].a, base + 32'(4 * i));
      check({tag, "/rtype"}, 32'(mem_log[i].t), 32'(MEM_R));
    end
  endtask

  task automatic drive(input mem_access_t t, input bit [31:0] a, input bit [31:0] d,
                       input bit cach, input bit io);
    cpu_bus.access_type = t;
    cpu_bus.addr        = a;
    cpu_bus.data_out    = d;
    cpu_bus.cachable    = cach;
    cpu_bus.io          = io;
  endtask

  task automatic access(input string tag, input mem_access_t t, input bit [31:0] a,
                        input bit [31:0] d, input bit cach, input bit io);
    bit        byp   = io || !cach;
    int        idx   = int'(a[TLSB-1:ILSB]);
    int        w     = int'(a[ILSB-1:2]);
    bit        lhit  = line_hit(a);
    bit        rhit  = !byp && (t != MEM_W) && lhit;
    bit [31:0] exp_d = rhit ? cdata[idx][w] : mem_rd(a);
    int        cyc   = 0;
    bit        seen  = 1'b0;
    logic [31:0] got = '0;
    @(posedge clk); #1;
    mem_log.delete();
    drive(t, a, d, cach, io);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_bus.ready === 1'b1) begin
        seen = 1'b1;
        got  = cpu_bus.data_in;
      end
    end
    @(posedge clk); #1;
    cpu_bus.access_type = MEM_NONE;
    check({tag, "/ready"}, 32'(seen), 32'd1);
    if (t != MEM_W) check({tag, "/data"}, got, exp_d);
    if (byp || t == MEM_W) begin
      check({tag, "/nops"}, mem_log.size(), 1);
      if (mem_log.size() > 0) begin
        check({tag, "/type"}, 32'(mem_log[0].t), 32'(t));
        check({tag, "/addr"}, mem_log[0].a, a);
        if (t == MEM_W) check({tag, "/wdata"}, mem_log[0].d, d);
      end
      if (!byp && lhit) cdata[idx][w] = d;
    end else if (rhit) begin
      check({tag, "/nops"}, mem_log.size(), 0);
      check({tag, "/lat"}, cyc, 2);
    end else begin
      check_refill(tag, a);
      install(a);
    end
  endtask

  task automatic wait_ops(input int n);
    int cyc = 0;
    while (mem_log.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic abort_read(input bit [31:0] a);
    int rc;
    @(posedge clk); #1;
    mem_log.delete();
    rc = ready_cnt;
    drive(MEM_R, a, 32'h0, 1'b1, 1'b0);
    wait_ops(1);
    @(posedge clk); #1;
    cpu_bus.access_type = MEM_NONE;
    wait_ops(NWORD);
    repeat (4) @(negedge clk);
    #1;
    check("abort/no_ready", ready_cnt, rc);
    check_refill("abort", a);
    install(a);
  endtask

  task automatic reset_mid_refill(input bit [31:0] a);
    @(posedge clk); #1;
    mem_log.delete();
    drive(MEM_R, a, 32'h0, 1'b1, 1'b0);
    wait_ops(1);
    @(posedge clk); #1;
    res = 1'b0;
    cpu_bus.access_type = MEM_NONE;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid/mem_type", 32'(mem_bus.access_type), 32'(MEM_NONE));
    check("rst_mid/mem_addr", mem_bus.addr, 32'h0);
    check("rst_mid/cpu_ready", 32'(cpu_bus.ready), 32'd0);
    @(posedge clk); #1;
    res = 1'b1;
    for (int i = 0; i < NLINE; i++) cv[i] = 1'b0;
  endtask

  initial begin
    res = 1'b0;
    drive(MEM_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/cpu_ready", 32'(cpu_bus.ready), 32'd0);
    check("rst/cpu_data", cpu_bus.data_in, 32'h0);
    check("rst/mem_type", 32'(mem_bus.access_type), 32'(MEM_NONE));
    check("rst/mem_addr", mem_bus.addr, 32'h0);
    check("rst/mem_wdata", mem_bus.data_out, 32'h0);
    @(posedge clk); #1;
    res = 1'b1;

    access("cold_rd",    MEM_R, 32'h0000_1004, 32'h0, 1'b1, 1'b0);
    access("hit_rd",     MEM_R, 32'h0000_1008, 32'h0, 1'b1, 1'b0);
    access("wr_hit",     MEM_W, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1'b0);
    access("rd_after_w", MEM_R, 32'h0000_1004, 32'h0, 1'b1, 1'b0);
    access("wr_miss",    MEM_W, 32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0);
    access("rd_no_alloc",MEM_R, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
    access("io_rd1",     MEM_R, 32'hBFD0_0000, 32'h0, 1'b1, 1'b1);
    access("io_rd2",     MEM_R, 32'hBFD0_0000, 32'h0, 1'b1, 1'b1);
    access("x_hit",      MEM_X, 32'h0000_100C, 32'h0, 1'b1, 1'b0);
    access("conf_a",     MEM_R, 32'h0000_1000, 32'h0, 1'b1, 1'b0);
    access("conf_b",     MEM_R, 32'h0000_1000 + (32'h1 << TLSB), 32'h0, 1'b1, 1'b0);
    access("conf_a2",    MEM_R, 32'h0000_1000, 32'h0, 1'b1, 1'b0);
    abort_read(32'h0000_3000);
    access("post_abort", MEM_R, 32'h0000_3004, 32'h0, 1'b1, 1'b0);
    reset_mid_refill(32'h0000_5000);
    access("post_rst",   MEM_R, 32'h0000_5000, 32'h0, 1'b1, 1'b0);
    access("post_rst2",  MEM_R, 32'h0000_1000, 32'h0, 1'b1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      int          r  = $urandom_range(0, 9);
      mem_access_t t  = (r < 3) ? MEM_W : ((r == 3) ? MEM_X : MEM_R);
      bit [31:0]   a  = (32'($urandom_range(1, 3)) << TLSB) |
                        (32'($urandom_range(0, 7)) << ILSB) |
                        (32'($urandom_range(0, NWORD - 1)) << 2);
      bit          ca = ($urandom_range(0, 9) != 0);
      bit          io = ($urandom_range(0, 19) == 0);
      access("rand", t, a, $urandom, ca, io);
    end

    repeat (2) @(negedge clk);
    check("no_double_ready", dbl_rdy, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
